// File: rtl/full_c_led_pkg.sv
// full_c_led_pkg: shared constants and the button-to-LED-channel mapping for
// the 4x RGB LED controller.
//   NUM_LEDS / NUM_COLORS / NUM_BTNS : bank geometry
//   CLR_R / CLR_G / CLR_B            : color index within one LED
//   btn_to_chan()                    : button index -> (led, color)
//   chan_index()                     : (led, color) -> flat color-register bit
package full_c_led_pkg;

  localparam int unsigned NUM_LEDS   = 4;
  localparam int unsigned NUM_COLORS = 3;
  localparam int unsigned NUM_BTNS   = NUM_LEDS * NUM_COLORS;

  localparam int unsigned CLR_R = 0;
  localparam int unsigned CLR_G = 1;
  localparam int unsigned CLR_B = 2;

  typedef struct packed {
    logic [1:0] led;
    logic [1:0] color;
  } chan_t;

  // Button b(3k+1+c) (zero-based index 3k+c) drives LED k, color c.
  function automatic chan_t btn_to_chan(input int unsigned btn);
    chan_t c;
    c.led   = 2'(btn / NUM_COLORS);
    c.color = 2'(btn % NUM_COLORS);
    return c;
  endfunction

  function automatic int unsigned chan_index(input chan_t c);
    return 32'(c.led) * NUM_COLORS + 32'(c.color);
  endfunction

endpackage

// File: rtl/full_c_led_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer plus debounce counter for one raw button.
//   clk, rst_n : clock, async active-low reset
//   i_btn      : raw, asynchronous, possibly bouncing button (active-high)
//   o_press    : one-cycle pulse in the cycle the debounced level goes 0->1
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      if (r_sync == r_stable) begin
        // Any return to the accepted level discards the partial count.
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Combinational so the color bit toggles on the same edge stable rises.
  assign o_press = r_sync & ~r_stable & (r_cnt == CNT_MAX);

endmodule

// File: rtl/full_c_led_ctrl.sv
// full_c_led_ctrl: 12 debounced buttons each toggle one color channel of a
// 4x RGB LED bank; the latched colors are gated by a free-running PWM and
// registered onto the LED pins.
//   clk, rst_n        : clock, async active-low reset
//   b1 .. b12         : raw buttons; b(3k+1/2/3) -> LED k+1 red/green/blue
//   led_<n>_<r|g|b>   : registered, active-high LED color pins
module full_c_led_ctrl
  import full_c_led_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned DUTY       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic b4,
  input  logic b5,
  input  logic b6,
  input  logic b7,
  input  logic b8,
  input  logic b9,
  input  logic b10,
  input  logic b11,
  input  logic b12,
  output logic led_1_r,
  output logic led_1_g,
  output logic led_1_b,
  output logic led_2_r,
  output logic led_2_g,
  output logic led_2_b,
  output logic led_3_r,
  output logic led_3_g,
  output logic led_3_b,
  output logic led_4_r,
  output logic led_4_g,
  output logic led_4_b
);

  localparam int unsigned IDX_W = $clog2(NUM_BTNS);

  logic [NUM_BTNS-1:0] w_btn;
  logic [NUM_BTNS-1:0] w_press;
  logic [NUM_BTNS-1:0] w_color_d;
  logic [IDX_W-1:0]    w_idx;
  logic                w_pwm_on;

  logic [NUM_BTNS-1:0] r_color;
  logic [NUM_BTNS-1:0] r_led;
  logic [PWM_BITS-1:0] r_pwm_cnt;

  assign w_btn = {b12, b11, b10, b9, b8, b7, b6, b5, b4, b3, b2, b1};

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_btn  (w_btn[g]),
      .o_press(w_press[g])
    );
  end

  always_comb begin
    w_color_d = r_color;
    w_idx     = '0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      w_idx = IDX_W'(chan_index(btn_to_chan(i)));
      if (w_press[i]) begin
        w_color_d[w_idx] = ~r_color[w_idx];
      end
    end
  end

  // DUTY >= 2^PWM_BITS keeps this true for every count value (always on).
  assign w_pwm_on = (32'(r_pwm_cnt) < DUTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_color   <= '0;
      r_led     <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_color   <= w_color_d;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_led     <= r_color & {NUM_BTNS{w_pwm_on}};
    end
  end

  assign led_1_r = r_led[0 * NUM_COLORS + CLR_R];
  assign led_1_g = r_led[0 * NUM_COLORS + CLR_G];
  assign led_1_b = r_led[0 * NUM_COLORS + CLR_B];
  assign led_2_r = r_led[1 * NUM_COLORS + CLR_R];
  assign led_2_g = r_led[1 * NUM_COLORS + CLR_G];
  assign led_2_b = r_led[1 * NUM_COLORS + CLR_B];
  assign led_3_r = r_led[2 * NUM_COLORS + CLR_R];
  assign led_3_g = r_led[2 * NUM_COLORS + CLR_G];
  assign led_3_b = r_led[2 * NUM_COLORS + CLR_B];
  assign led_4_r = r_led[3 * NUM_COLORS + CLR_R];
  assign led_4_g = r_led[3 * NUM_COLORS + CLR_G];
  assign led_4_b = r_led[3 * NUM_COLORS + CLR_B];

endmodule

// File: tb/tb_full_c_led_ctrl.sv
// Testbench for full_c_led_ctrl. Three instances share clock, reset and
// buttons: DUTY=16 (always on), DUTY=4 and DUTY=0. Output vectors are indexed
// by zero-based button number (bit 0 = led_1_r ... bit 11 = led_4_b).
module tb_full_c_led_ctrl;

  logic clk;
  logic rst_n;
  logic [11:0] btn;
  logic [11:0] o16, o4, o0;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_color = '0;

  // Reference PWM phase for the DUTY=4 instance.
  logic [3:0] m_pwm;
  logic       m_on4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pwm <= '0;
      m_on4 <= 1'b0;
    end else begin
      m_pwm <= m_pwm + 4'd1;
      m_on4 <= (m_pwm < 4'd4);
    end
  end

  full_c_led_ctrl #(.DEB_CYCLES(16), .PWM_BITS(4), .DUTY(16)) u_d16 (
    .clk(clk), .rst_n(rst_n),
    .b1(btn[0]), .b2(btn[1]), .b3(btn[2]), .b4(btn[3]), .b5(btn[4]), .b6(btn[5]),
    .b7(btn[6]), .b8(btn[7]), .b9(btn[8]), .b10(btn[9]), .b11(btn[10]), .b12(btn[11]),
    .led_1_r(o16[0]), .led_1_g(o16[1]), .led_1_b(o16[2]),
    .led_2_r(o16[3]), .led_2_g(o16[4]), .led_2_b(o16[5]),
    .led_3_r(o16[6]), .led_3_g(o16[7]), .led_3_b(o16[8]),
    .led_4_r(o16[9]), .led_4_g(o16[10]), .led_4_b(o16[11])
  );

  full_c_led_ctrl #(.DEB_CYCLES(16), .PWM_BITS(4), .DUTY(4)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .b1(btn[0]), .b2(btn[1]), .b3(btn[2]), .b4(btn[3]), .b5(btn[4]), .b6(btn[5]),
    .b7(btn[6]), .b8(btn[7]), .b9(btn[8]), .b10(btn[9]), .b11(btn[10]), .b12(btn[11]),
    .led_1_r(o4[0]), .led_1_g(o4[1]), .led_1_b(o4[2]),
    .led_2_r(o4[3]), .led_2_g(o4[4]), .led_2_b(o4[5]),
    .led_3_r(o4[6]), .led_3_g(o4[7]), .led_3_b(o4[8]),
    .led_4_r(o4[9]), .led_4_g(o4[10]), .led_4_b(o4[11])
  );

  full_c_led_ctrl #(.DEB_CYCLES(16), .PWM_BITS(4), .DUTY(0)) u_d0 (
    .clk(clk), .rst_n(rst_n),
    .b1(btn[0]), .b2(btn[1]), .b3(btn[2]), .b4(btn[3]), .b5(btn[4]), .b6(btn[5]),
    .b7(btn[6]), .b8(btn[7]), .b9(btn[8]), .b10(btn[9]), .b11(btn[10]), .b12(btn[11]),
    .led_1_r(o0[0]), .led_1_g(o0[1]), .led_1_b(o0[2]),
    .led_2_r(o0[3]), .led_2_g(o0[4]), .led_2_b(o0[5]),
    .led_3_r(o0[6]), .led_3_g(o0[7]), .led_3_b(o0[8]),
    .led_4_r(o0[9]), .led_4_g(o0[10]), .led_4_b(o0[11])
  );

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    btn   = '0;
    step(3);
    checks++;
    if (o16 !== 12'h000 || o4 !== 12'h000 || o0 !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold: o16=%h o4=%h o0=%h required 000", o16, o4, o0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      checks++;
      if (o16 !== 12'h000 || o4 !== 12'h000 || o0 !== 12'h000) begin
        errors++;
        $display("FAIL idle cyc%0d: o16=%h o4=%h o0=%h required 000", i, o16, o4, o0);
      end
    end
  endtask

  task automatic test_clean_press;
    btn[0] = 1'b1;
    step(18);
    checks++;
    if (o16 !== exp_color) begin
      errors++;
      $display("FAIL press1_E18: o16=%h required %h", o16, exp_color);
    end
    step(1);
    exp_color[0] = 1'b1;
    checks++;
    if (o16 !== exp_color) begin
      errors++;
      $display("FAIL press1_E19: o16=%h required %h", o16, exp_color);
    end
    for (int i = 0; i < 21; i++) begin
      step(1);
      checks++;
      if (o16 !== exp_color) begin
        errors++;
        $display("FAIL press1_hold cyc%0d: o16=%h required %h", i, o16, exp_color);
      end
    end
    btn[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      checks++;
      if (o16 !== exp_color) begin
        errors++;
        $display("FAIL release1 cyc%0d: o16=%h required %h", i, o16, exp_color);
      end
    end
    btn[0] = 1'b1;
    step(18);
    checks++;
    if (o16 !== exp_color) begin
      errors++;
      $display("FAIL press2_E18: o16=%h required %h", o16, exp_color);
    end
    step(1);
    exp_color[0] = 1'b0;
    checks++;
    if (o16 !== exp_color) begin
      errors++;
      $display("FAIL press2_E19: o16=%h required %h", o16, exp_color);
    end
    btn[0] = 1'b0;
    step(25);
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 10; i++) begin
      btn[4] = (i % 2 == 0);
      for (int j = 0; j < 3; j++) begin
        step(1);
        checks++;
        if (o16 !== exp_color) begin
          errors++;
          $display("FAIL bounce seg%0d: o16=%h required %h", i, o16, exp_color);
        end
      end
    end
    btn[4] = 1'b1;
    step(18);
    checks++;
    if (o16 !== exp_color) begin
      errors++;
      $display("FAIL bounce_E18: o16=%h required %h", o16, exp_color);
    end
    step(1);
    exp_color[4] = 1'b1;
    checks++;
    if (o16 !== 12'h010) begin
      errors++;
      $display("FAIL bounce_E19: o16=%h required 010", o16);
    end
    step(20);
    checks++;
    if (o16 !== 12'h010) begin
      errors++;
      $display("FAIL bounce_held: o16=%h required 010", o16);
    end
    btn[4] = 1'b0;
    step(25);
  endtask

  task automatic test_simultaneous;
    btn = 12'h924;
    step(18);
    checks++;
    if (o16 !== exp_color) begin
      errors++;
      $display("FAIL simul_E18: o16=%h required %h", o16, exp_color);
    end
    step(1);
    exp_color = exp_color | 12'h924;
    checks++;
    if (o16 !== 12'h934) begin
      errors++;
      $display("FAIL simul_E19: o16=%h required 934", o16);
    end
    btn = '0;
    step(25);
    checks++;
    if (o16 !== 12'h934) begin
      errors++;
      $display("FAIL simul_release: o16=%h required 934", o16);
    end
  endtask

  task automatic test_pwm;
    int highs;
    highs = 0;
    btn[6] = 1'b1;
    step(19);
    exp_color[6] = 1'b1;
    btn[6] = 1'b0;
    step(25);
    for (int i = 0; i < 160; i++) begin
      step(1);
      checks++;
      if (o4 !== (exp_color & {12{m_on4}})) begin
        errors++;
        $display("FAIL pwm4 cyc%0d: o4=%h required %h", i, o4, exp_color & {12{m_on4}});
      end
      checks++;
      if (o0 !== 12'h000) begin
        errors++;
        $display("FAIL pwm0 cyc%0d: o0=%h required 000", i, o0);
      end
      if (o4[6]) highs++;
    end
    checks++;
    if (highs != 40) begin
      errors++;
      $display("FAIL pwm4_high_count: got %0d required 40", highs);
    end
    checks++;
    if (o16 !== exp_color) begin
      errors++;
      $display("FAIL pwm16_on: o16=%h required %h", o16, exp_color);
    end
  endtask

  task automatic test_reset_mid_count;
    btn[6] = 1'b1;
    step(12);  // internal count of b7 has reached 10
    #3;
    rst_n = 1'b0;
    #1;
    exp_color = '0;
    checks++;
    if (o16 !== 12'h000 || o4 !== 12'h000 || o0 !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: o16=%h o4=%h o0=%h required 000", o16, o4, o0);
    end
    step(2);
    rst_n = 1'b1;
    step(18);
    checks++;
    if (o16 !== 12'h000) begin
      errors++;
      $display("FAIL restart_E18: o16=%h required 000", o16);
    end
    step(1);
    exp_color[6] = 1'b1;
    checks++;
    if (o16 !== 12'h040) begin
      errors++;
      $display("FAIL restart_E19: o16=%h required 040", o16);
    end
    checks++;
    if (o4 !== (exp_color & {12{m_on4}})) begin
      errors++;
      $display("FAIL restart_pwm4: o4=%h required %h", o4, exp_color & {12{m_on4}});
    end
    btn[6] = 1'b0;
    step(5);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_pwm();
    test_reset_mid_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
